// File: rtl/fa_serial_ctrl.sv
// Bit-serial adder controller: one FA cell sequenced LSB-first over WIDTH bits,
// with a start handshake for operands and a valid/ack handshake for the result.

// Single-bit full adder cell shared by the serial datapath.
module FA (
    input  logic iA,
    input  logic iB,
    input  logic iC,
    output logic oS,
    output logic oC
);

    assign oS = iA ^ iB ^ iC;
    assign oC = (iA & iB) | (iA & iC) | (iB & iC);

endmodule

module fa_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    output logic             oReady,
    output logic             oBusy,
    output logic             oValid,
    input  logic             iAck,
    output logic [WIDTH-1:0] oS,
    output logic             oC
);

    localparam int unsigned    CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   sum_sr;
    logic [WIDTH-1:0]   sum_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
    logic               fa_s;
    logic               fa_c;

    FA u_fa (
        .iA (op_a[0]),
        .iB (op_b[0]),
        .iC (carry),
        .oS (fa_s),
        .oC (fa_c)
    );

    assign last_bit = (cnt == LAST);
    // New sum bit enters at the MSB while earlier bits move toward the LSB.
    assign sum_next = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    // State register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start only matters in IDLE, ack only in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (iStart)   state_d = RUN;
            RUN:  if (last_bit) state_d = DONE;
            DONE: if (iAck)     state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state so they track state_q exactly.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oReady <= 1'b1;
            oBusy  <= 1'b0;
            oValid <= 1'b0;
        end else begin
            oReady <= (state_d == IDLE);
            oBusy  <= (state_d == RUN);
            oValid <= (state_d == DONE);
        end
    end

    // Serial datapath: capture on start, shift one bit per RUN cycle, publish at the last bit.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            oS     <= '0;
            oC     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        op_a   <= iA;
                        op_b   <= iB;
                        carry  <= iC;
                        sum_sr <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= fa_c;
                    sum_sr <= sum_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        oS <= sum_next;
                        oC <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Directed and random checks of fa_serial_ctrl at WIDTH=8 and WIDTH=1.
module tb_fa_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, ack8, c8_in;
    logic [7:0] a8, b8;
    logic       ready8, busy8, valid8, c8_out;
    logic [7:0] s8_out;

    logic       start1, ack1;
    logic [0:0] a1, b1;
    logic       c1_in;
    logic       ready1, busy1, valid1, c1_out;
    logic [0:0] s1_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fa_serial_ctrl #(.WIDTH(8)) dut8 (
        .iClk(clk), .iRst(rst), .iStart(start8), .iA(a8), .iB(b8), .iC(c8_in),
        .oReady(ready8), .oBusy(busy8), .oValid(valid8), .iAck(ack8),
        .oS(s8_out), .oC(c8_out)
    );

    fa_serial_ctrl #(.WIDTH(1)) dut1 (
        .iClk(clk), .iRst(rst), .iStart(start1), .iA(a1), .iB(b1), .iC(c1_in),
        .oReady(ready1), .oBusy(busy1), .oValid(valid1), .iAck(ack1),
        .oS(s1_out), .oC(c1_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full WIDTH=8 transaction; returns result and edges from start to oValid.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int ack_dly,
                        output logic [7:0] s, output logic co, output int lat);
        start8 = 1'b1; a8 = a; b8 = b; c8_in = c;
        step();
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; c8_in = ~c;
        lat = 0;
        while (!valid8 && lat < 40) begin
            step();
            lat++;
        end
        s  = s8_out;
        co = c8_out;
        repeat (ack_dly) step();
        ack8 = 1'b1;
        step();
        ack8 = 1'b0;
    endtask

    task automatic run1(input logic a, input logic b, input logic c,
                        output logic s, output logic co, output int lat);
        start1 = 1'b1; a1 = a; b1 = b; c1_in = c;
        step();
        start1 = 1'b0;
        lat = 0;
        while (!valid1 && lat < 20) begin
            step();
            lat++;
        end
        s  = s1_out[0];
        co = c1_out;
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
    endtask

    initial begin
        logic [7:0] s;
        logic       co;
        logic       s_b;
        int         lat;
        int         busy_cnt;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] ref9;
        logic [1:0] ref2;

        rst = 1'b1;
        start8 = 1'b0; ack8 = 1'b0; a8 = '0; b8 = '0; c8_in = 1'b0;
        start1 = 1'b0; ack1 = 1'b0; a1 = '0; b1 = '0; c1_in = 1'b0;
        #12;
        check("reset_ready", 64'(ready8), 64'd1);
        check("reset_busy",  64'(busy8),  64'd0);
        check("reset_valid", 64'(valid8), 64'd0);
        check("reset_s",     64'(s8_out), 64'd0);
        check("reset_c",     64'(c8_out), 64'd0);
        rst = 1'b0;
        step();

        // 0x5A + 0x3C = 0x96
        run8(8'h5A, 8'h3C, 1'b0, 0, s, co, lat);
        check("t1_latency", 64'(lat), 64'd8);
        check("t1_s", 64'(s), 64'h96);
        check("t1_c", 64'(co), 64'd0);
        check("t1_ready_after_ack", 64'(ready8), 64'd1);
        check("t1_valid_after_ack", 64'(valid8), 64'd0);

        // Carry propagation across all bits
        run8(8'hFF, 8'h01, 1'b0, 1, s, co, lat);
        check("t2a_s", 64'(s), 64'h00);
        check("t2a_c", 64'(co), 64'd1);
        run8(8'hFF, 8'hFF, 1'b1, 2, s, co, lat);
        check("t2b_s", 64'(s), 64'hFF);
        check("t2b_c", 64'(co), 64'd1);

        // Start held and operands changed during RUN: 0x12 + 0x34 + 1 = 0x47
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8_in = 1'b1;
        step();
        busy_cnt = 0;
        lat = 0;
        while (!valid8 && lat < 40) begin
            if (busy8) busy_cnt++;
            if (lat == 3) begin
                a8 = 8'hFF; b8 = 8'hFF; c8_in = 1'b0;
            end
            step();
            lat++;
        end
        start8 = 1'b0;
        check("t3_busy_cycles", 64'(busy_cnt), 64'd8);
        check("t3_s", 64'(s8_out), 64'h47);
        check("t3_c", 64'(c8_out), 64'd0);

        ack8 = 1'b1;
        step();
        ack8 = 1'b0;

        // DONE hold: 0x80 + 0x80 = 0x100
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; c8_in = 1'b0;
        step();
        start8 = 1'b0;
        lat = 0;
        while (!valid8 && lat < 40) begin
            step();
            lat++;
        end
        check("t4_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold_valid", 64'(valid8), 64'd1);
            check("t4_hold_s",     64'(s8_out), 64'h00);
            check("t4_hold_c",     64'(c8_out), 64'd1);
        end
        start8 = 1'b1; ack8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        step();
        start8 = 1'b0; ack8 = 1'b0;
        check("t4_ready_after_ack", 64'(ready8), 64'd1);
        check("t4_valid_after_ack", 64'(valid8), 64'd0);
        step();
        step();
        check("t4_no_new_op_busy",  64'(busy8),  64'd0);
        check("t4_no_new_op_ready", 64'(ready8), 64'd1);

        // Async reset mid-RUN
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8_in = 1'b0;
        step();
        start8 = 1'b0;
        repeat (4) step();
        check("t5_busy_before_rst", 64'(busy8), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_ready", 64'(ready8), 64'd1);
        check("t5_rst_busy",  64'(busy8),  64'd0);
        check("t5_rst_valid", 64'(valid8), 64'd0);
        check("t5_rst_s",     64'(s8_out), 64'd0);
        check("t5_rst_c",     64'(c8_out), 64'd0);
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid8) busy_cnt++;
        end
        check("t5_no_valid_after_abort", 64'(busy_cnt), 64'd0);
        run8(8'h01, 8'h02, 1'b0, 0, s, co, lat);
        check("t5_s", 64'(s), 64'h03);
        check("t5_c", 64'(co), 64'd0);

        // Random regression against the integer sum
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            ref9 = 9'(ra) + 9'(rb) + 9'(rc);
            run8(ra, rb, rc, int'($urandom_range(0, 3)), s, co, lat);
            check("rand_sum", 64'({co, s}), 64'(ref9));
            check("rand_latency", 64'(lat), 64'd8);
        end

        // WIDTH=1 full-adder truth table
        for (int i = 0; i < 8; i++) begin
            ra = 8'(i);
            ref2 = 2'(ra[2]) + 2'(ra[1]) + 2'(ra[0]);
            run1(ra[2], ra[1], ra[0], s_b, co, lat);
            check("w1_sum", 64'({co, s_b}), 64'(ref2));
            check("w1_latency", 64'(lat), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fa_serial_ctrl.md
Name: fa_serial_ctrl

Overview:
- Bit-serial adder controller that time-shares one `FA` full-adder instance across a WIDTH-bit addition.
- Accepts two operands and a carry-in through a start handshake.
- Feeds the FA one bit per clock, LSB first, and keeps the carry in a register between bits.
- Presents the WIDTH-bit sum and final carry-out through a valid/ack handshake.
- Serves as the sequencing layer over the existing `FA` cell for area-constrained arithmetic paths.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
iClk  input  1  clock, rising-edge active
iRst  input  1  asynchronous active-high reset
iStart  input  1  request to begin an addition; sampled only in IDLE
iA  input  WIDTH  operand A, captured on the accepted start edge
iB  input  WIDTH  operand B, captured on the accepted start edge
iC  input  1  carry-in, captured on the accepted start edge
oReady  output  1  high in IDLE; start is accepted when iStart && oReady
oBusy  output  1  high in RUN
oValid  output  1  high in DONE; result is valid
iAck  input  1  consumer acknowledge; sampled only in DONE
oS  output  WIDTH  sum result
oC  output  1  final carry-out

Behaviour:
- Reset (async, iRst=1):
  - state=IDLE; oReady=1, oBusy=0, oValid=0, oS=0, oC=0.
  - Internal operand shift registers, carry register and bit counter all cleared.
- Internal datapath:
  - One `FA` instance.
  - Inputs: iA=opA[0], iB=opB[0], iC=carry register.
- IDLE:
  - On a rising edge with iStart=1: latch iA->opA, iB->opB, iC->carry; clear counter to 0; go to RUN.
  - oS/oC keep the previous result until the next start; they are not cleared.
- RUN, each edge:
  - The FA sum bit enters sum register bit WIDTH-1 and the register shifts right 1.
  - FA carry-out -> carry register.
  - opA and opB shift right 1; counter increments.
  - At the edge where counter==WIDTH-1: transition to DONE and load oC from the FA carry-out.
- Latency: start accepted at edge k -> oValid=1 after edge k+WIDTH. For WIDTH=1 this is exactly one RUN cycle.
- DONE:
  - oValid=1; oS and oC held stable.
  - On an edge with iAck=1: go to IDLE, oValid=0 and oReady=1 from the next cycle.
  - With no ack, DONE holds indefinitely.
- Ignored inputs:
  - iStart outside IDLE is ignored and not queued.
  - iAck outside DONE is ignored.
  - iStart and iAck both high in DONE: the ack is taken and the start is ignored; a new start is needed in IDLE.
- Operand stability: iA/iB/iC may change freely after the start edge; results depend only on the captured values.
- Arithmetic: {oC,oS} = iA + iB + iC exactly, evaluated modulo 2^(WIDTH+1).
- Reset mid-RUN or mid-DONE: immediate abort to IDLE with the reset values above; no oValid pulse is produced for the aborted operation.
- One-hot outputs: exactly one of oReady/oBusy/oValid is high at any time after reset.

Test Plan:
1. WIDTH=8, start with iA=0x5A, iB=0x3C, iC=0 -> oValid rises 8 cycles after the start edge; oS=0x96, oC=0; iAck -> oReady=1 next cycle.
2. iA=0xFF, iB=0x01, iC=0 -> oS=0x00, oC=1. Then iA=0xFF, iB=0xFF, iC=1 -> oS=0xFF, oC=1.
3. Pulse iStart again and change iA/iB at cycle 3 of RUN -> no restart; the result matches the originally captured operands; oBusy stays high for exactly 8 cycles.
4. Hold iAck low for 5 cycles in DONE -> oValid, oS and oC stable throughout. Assert iStart+iAck together -> return to IDLE with no new operation started.
5. Assert iRst at RUN cycle 4 -> asynchronously all outputs 0 except oReady=1. Next operation 0x01+0x02+0 -> oS=0x03, oC=0.
6. Random regression: 1000 random {iA, iB, iC} with random ack delays 0..3 -> {oC,oS} equals reference iA+iB+iC. Repeat with WIDTH=1 over all 8 input combinations, matching the full-adder truth table.
